seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param_pkg.sv | 45 ++++
 rtl/seq_detector_param_counter.sv | 34 +++
 rtl/seq_detector_param.sv | 76 +++++++
 tb/tb_seq_detector_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// state-width derivation, overlap mode constants and the KMP transition function.
package seq_detector_param_pkg;

  localparam bit OVERLAP_ON  = 1'b1;
  localparam bit OVERLAP_OFF = 1'b0;
  localparam int MAX_LEN     = 16;

  function automatic int state_width(input int len);
    return $clog2(len + 1);
  endfunction

  // Next state index from S_k on input bit x. pattern[len-1] is the first bit
  // expected. The answer is the longest pattern prefix that is a suffix of
  // (first k pattern bits, then x); a matching x therefore yields k+1.
  function automatic int next_index(input int k, input logic x,
                                    input logic [MAX_LEN-1:0] pattern,
                                    input int len, input bit overlap);
    logic [MAX_LEN:0] seq;
    int               m;
    int               best;
    bit               ok;
    if (k >= len && overlap == OVERLAP_OFF) begin
      return (x == pattern[len-1]) ? 1 : 0;
    end
    seq = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < k) seq[i] = pattern[len-1-i];
    end
    seq[k] = x;
    m      = k + 1;
    best   = 0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (j <= len && j <= m) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_LEN; t++) begin
          if (t < j && seq[m-j+t] != pattern[len-1-t]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detector_param_counter.sv
// Saturating detection counter with synchronous clear, qualified increment
// and a sticky saturation flag.
import seq_detector_param_pkg::*;

module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  // Clear wins over a simultaneous increment; at all-ones the count holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt_inc;
      if (&cnt_inc) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial sequence detector for an arbitrary LEN-bit MSB-first pattern,
// with sample enable and a saturating match counter.
import seq_detector_param_pkg::*;

module seq_detector_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  parameter int             SW      = state_width(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             y,
  output logic [SW-1:0]    state_o,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int          NS     = LEN + 1;
  localparam int          TW     = 2 * NS * SW;
  localparam logic [SW-1:0] S_LAST = SW'(LEN);

  // Entry (2*k + x) holds the successor of S_k on input x.
  function automatic logic [TW-1:0] build_table();
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < NS; k++) begin
      for (int b = 0; b < 2; b++) begin
        t[(2*k+b)*SW +: SW] = SW'(next_index(k, b[0], MAX_LEN'(PATTERN), LEN, OVERLAP));
      end
    end
    return t;
  endfunction

  localparam logic [TW-1:0] TAB = build_table();

  logic [SW-1:0] state;
  logic [SW-1:0] next_state;
  logic          hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= '0;
    else      state <= next_state;
  end

  // Encodings above S_LEN are unreachable; they fall back to S0.
  always_comb begin
    next_state = state;
    if (en) begin
      if (state <= S_LAST) next_state = TAB[(2*int'(state) + int'(x))*SW +: SW];
      else                 next_state = '0;
    end
  end

  always_comb begin
    y       = (state == S_LAST);
    state_o = state;
    hit     = en && (next_state == S_LAST);
  end

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk(clk),
    .rst(rst),
    .clr(clr_cnt),
    .inc(hit),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four parameterisations driven by one stimulus
// stream and compared against a suffix-search reference model.
module tb_seq_detector_param;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic x = 1'b0;
  logic clr_cnt = 1'b0;

  logic       y0, y1, y2, y3;
  logic [2:0] st0, st1, st2, st3;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [2:0] cnt3;
  logic       sat0, sat1, sat2, sat3;

  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(y0), .state_o(st0), .match_cnt(cnt0), .cnt_sat(sat0));
  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(y1), .state_o(st1), .match_cnt(cnt1), .cnt_sat(sat1));
  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(y2), .state_o(st2), .match_cnt(cnt2), .cnt_sat(sat2));
  seq_detector_param #(.LEN(6), .PATTERN(6'b110110), .OVERLAP(1'b0), .CNT_W(3)) dut_l6 (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .y(y3), .state_o(st3), .match_cnt(cnt3), .cnt_sat(sat3));

  // clock / reset
  always #5 clk = ~clk;

  // reference model: pattern and mode per instance, history of accepted bits
  int          m_len[NI] = '{4, 4, 4, 6};
  logic [15:0] m_pat[NI] = '{16'h000B, 16'h000B, 16'h000B, 16'h0036};
  bit          m_ovl[NI] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int          m_cw[NI]  = '{8, 8, 2, 3};
  int          m_hist[NI];
  int          m_hl[NI];
  int          m_st[NI];
  int          m_cnt[NI];
  bit          m_sat[NI];

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Longest prefix of the pattern that equals a suffix of the history.
  function automatic int match_len(input int h, input int hl, input int p, input int l);
    int mask;
    for (int j = l; j >= 1; j--) begin
      mask = (1 << j) - 1;
      if (j <= hl && ((h & mask) == ((p >> (l - j)) & mask))) return j;
    end
    return 0;
  endfunction

  function automatic logic [31:0] observed(input int i, input int f);
    logic [31:0] v;
    v = '0;
    case (i)
      0: case (f) 0: v = 32'(st0); 1: v = 32'(y0); 2: v = 32'(cnt0); default: v = 32'(sat0); endcase
      1: case (f) 0: v = 32'(st1); 1: v = 32'(y1); 2: v = 32'(cnt1); default: v = 32'(sat1); endcase
      2: case (f) 0: v = 32'(st2); 1: v = 32'(y2); 2: v = 32'(cnt2); default: v = 32'(sat2); endcase
      default: case (f) 0: v = 32'(st3); 1: v = 32'(y3); 2: v = 32'(cnt3); default: v = 32'(sat3); endcase
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_hist[i] = 0; m_hl[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit e, input bit xv, input bit c);
    int cmax;
    bit hit;
    for (int i = 0; i < NI; i++) begin
      cmax = (1 << m_cw[i]) - 1;
      hit  = 1'b0;
      if (e) begin
        m_hist[i] = ((m_hist[i] << 1) | int'(xv)) & 16'hFFFF;
        if (m_hl[i] < 16) m_hl[i]++;
        m_st[i] = match_len(m_hist[i], m_hl[i], int'(m_pat[i]), m_len[i]);
        hit = (m_st[i] == m_len[i]);
        if (hit && !m_ovl[i]) m_hl[i] = 0;
      end
      if (c) begin
        m_cnt[i] = 0;
        m_sat[i] = 1'b0;
      end else if (hit && m_cnt[i] < cmax) begin
        m_cnt[i]++;
        if (m_cnt[i] == cmax) m_sat[i] = 1'b1;
      end
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < NI; i++) begin
      exp_q.push_back(32'(m_st[i]));
      exp_q.push_back(32'(m_st[i] == m_len[i]));
      exp_q.push_back(32'(m_cnt[i]));
      exp_q.push_back(32'(m_sat[i]));
    end
  endtask

  task automatic compare_all(input string tag);
    string names[4] = '{"state", "y", "cnt", "sat"};
    for (int i = 0; i < NI; i++) begin
      for (int f = 0; f < 4; f++) begin
        check($sformatf("%s_i%0d_%s", tag, i, names[f]), observed(i, f), exp_q.pop_front());
      end
    end
  endtask

  // driver tasks
  task automatic step(input bit e, input bit xv, input bit c, input string tag);
    @(negedge clk);
    en = e; x = xv; clr_cnt = c;
    @(posedge clk);
    model_edge(e, xv, c);
    push_expected();
    #1;
    compare_all(tag);
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input string tag);
    logic [31:0] b;
    b = bits;
    for (int k = n - 1; k >= 0; k--) step(1'b1, b[k], 1'b0, tag);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    en = 1'b0; x = 1'b0; clr_cnt = 1'b0;
    #1 rst = 1'b0;
    #1;
    model_reset();
    push_expected();
    compare_all(tag);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    #3;
    push_expected();
    compare_all("por");
    #4 rst = 1'b1;

    // 1: reset mid-sequence, no clock edge needed
    feed(32'b101, 3, "t1");
    apply_reset("t1_rst");

    // 2/3: overlapping vs non-overlapping on the same stream
    feed(32'b1011011, 7, "t23");
    apply_reset("t23_rst");

    // 4: failure path
    feed(32'b111011, 6, "t4");
    apply_reset("t4_rst");

    // 5: enable gating with x=1 during the gap
    feed(32'b10, 2, "t5a");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, "t5gap");
    feed(32'b11, 2, "t5b");
    apply_reset("t5_rst");

    // 6: saturation of the narrow counter, then clear on a detecting edge
    feed(32'b1011011011011011, 16, "t6");
    feed(32'b01, 2, "t6b");
    step(1'b1, 1'b1, 1'b1, "t6clr");
    apply_reset("t6_rst");

    // randomized traffic with occasional clears and resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) apply_reset("rnd_rst");
      else step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 59) == 0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
